// File: rtl/lc3_fetch_pkg.sv
// Shared types and constants for the LC3 prefetching fetch stage.
package lc3_fetch_pkg;

  localparam logic [15:0] LC3_RESET_PC = 16'h3000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SQUASH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] npc;
  } fetch_entry_t;

endpackage

// File: rtl/lc3_sync_fifo.sv
// Synchronous FIFO with flush and a registered head word, used as the prefetch queue.
module lc3_sync_fifo
  import lc3_fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d, rd_next_s;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             push_s, pop_s;

  assign pop_s     = pop_i && (count_q != {CW{1'b0}});
  assign push_s    = push_i && ((count_q != CW'(DEPTH)) || pop_s);
  assign rd_next_s = rd_q + PTR_ONE;

  // Next-state for pointers, occupancy and the head word (bypass when the queue is empty).
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    head_d  = head_q;
    if (flush_i) begin
      rd_d    = {AW{1'b0}};
      wr_d    = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (push_s) wr_d = wr_q + PTR_ONE;
      else        wr_d = wr_q;
      if (pop_s)  rd_d = rd_next_s;
      else        rd_d = rd_q;
      count_d = count_q + CW'(push_s) - CW'(pop_s);
      if (push_s && ((count_q == {CW{1'b0}}) || (pop_s && (count_q == CW'(1))))) begin
        head_d = din_i;
      end else if (pop_s) begin
        head_d = mem_q[rd_next_s];
      end else begin
        head_d = head_q;
      end
    end
    valid_d = (count_d != {CW{1'b0}});
  end

  // Storage array; contents are only observed through the reset head register.
  always_ff @(posedge clock) begin
    if (push_s && !flush_i) mem_q[wr_q] <= din_i;
  end

  // Pointer, occupancy and head registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_q    <= {AW{1'b0}};
      wr_q    <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
      head_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/lc3_prefetch_fetch.sv
// LC3 fetch stage: runs sequential instruction reads ahead of decode into a prefetch queue,
// flushing and redirecting on a taken branch.
module lc3_prefetch_fetch
  import lc3_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              INSTR_W  = 16,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = LC3_RESET_PC,
  localparam int             CW       = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_fetch,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  taddr,
  output logic [ADDR_W-1:0]  pc,
  output logic               instrmem_rd,
  input  logic [INSTR_W-1:0] Instr_dout,
  input  logic               complete_instr,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  npc_out,
  output logic [CW-1:0]      q_count
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_e              state_q, state_d;
  logic [ADDR_W-1:0]         fpc_q, fpc_d, pc_q, pc_d, fpc_inc_s;
  logic                      rd_q, rd_d;
  logic                      push_s, pop_s, space_after_push_s;
  logic [INSTR_W+ADDR_W-1:0] head_s;

  assign fpc_inc_s = fpc_q + PC_ONE;
  assign pop_s     = enable_fetch && instr_valid;
  // The completing request's slot was reserved at issue, so the follow-on needs one more.
  assign space_after_push_s = (q_count < CW'(DEPTH - 1)) || pop_s;

  lc3_sync_fifo #(
    .WIDTH (INSTR_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (enable_fetch),
    .flush_i (br_taken),
    .din_i   ({Instr_dout, fpc_inc_s}),
    .head_o  (head_s),
    .valid_o (instr_valid),
    .count_o (q_count)
  );

  // Request FSM: issue, hold until completion, and drop data of a request overtaken by a branch.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    push_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (br_taken) begin
          fpc_d   = taddr;
          pc_d    = taddr;
          rd_d    = 1'b1;
          state_d = REQ;
        end else if (q_count < CW'(DEPTH)) begin
          pc_d    = fpc_q;
          rd_d    = 1'b1;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (br_taken) begin
          fpc_d = taddr;
          if (complete_instr) begin
            pc_d    = taddr;
            state_d = REQ;
          end else begin
            state_d = SQUASH;
          end
        end else if (complete_instr) begin
          push_s = 1'b1;
          fpc_d  = fpc_inc_s;
          if (space_after_push_s) begin
            pc_d    = fpc_inc_s;
            state_d = REQ;
          end else begin
            rd_d    = 1'b0;
            state_d = IDLE;
          end
        end else begin
          state_d = REQ;
        end
      end
      SQUASH: begin
        if (br_taken) fpc_d = taddr;
        else          fpc_d = fpc_q;
        if (complete_instr) begin
          pc_d    = br_taken ? taddr : fpc_q;
          state_d = REQ;
        end else begin
          state_d = SQUASH;
        end
      end
      default: begin
        rd_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, fetch PC and the registered memory request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC;
      pc_q    <= RESET_PC;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
    end
  end

  assign pc          = pc_q;
  assign instrmem_rd = rd_q;
  assign instr_out   = head_s[INSTR_W+ADDR_W-1:ADDR_W];
  assign npc_out     = head_s[ADDR_W-1:0];

endmodule

// File: tb/tb_lc3_prefetch_fetch.sv
// Directed bench for lc3_prefetch_fetch with a variable-latency instruction memory model.
module tb_lc3_prefetch_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_fetch;
  logic        br_taken;
  logic [15:0] taddr;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [15:0] npc_out;
  logic [2:0]  q_count;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int wcnt = 0;
  int n_req = 0;
  logic [15:0] last_pc = 16'h0000;

  lc3_prefetch_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .enable_fetch   (enable_fetch),
    .br_taken       (br_taken),
    .taddr          (taddr),
    .pc             (pc),
    .instrmem_rd    (instrmem_rd),
    .Instr_dout     (Instr_dout),
    .complete_instr (complete_instr),
    .instr_valid    (instr_valid),
    .instr_out      (instr_out),
    .npc_out        (npc_out),
    .q_count        (q_count)
  );

  initial forever #5 clock = ~clock;

  function automatic logic [15:0] memv(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory answers the held request after lat cycles.
  task automatic mem_drive();
    if (instrmem_rd) begin
      if (wcnt >= lat - 1) begin
        complete_instr = 1'b1;
        Instr_dout = memv(pc);
        wcnt = 0;
        n_req++;
        last_pc = pc;
      end else begin
        complete_instr = 1'b0;
        wcnt++;
      end
    end else begin
      complete_instr = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    mem_drive();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    complete_instr = 1'b0;
    Instr_dout = 16'h0000;
    wcnt = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    n_req = 0;
    mem_drive();
  endtask

  initial begin
    reset = 1'b0;
    enable_fetch = 1'b0;
    br_taken = 1'b0;
    taddr = 16'h0000;
    Instr_dout = 16'h0000;
    complete_instr = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_rd", instrmem_rd, 0);
    chk("rst_pc", pc, 16'h3000);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_npc", npc_out, 0);
    chk("rst_count", q_count, 0);

    // 1: streaming with a 1-cycle memory and continuous pops
    reset = 1'b1;
    enable_fetch = 1'b1;
    lat = 1;
    mem_drive();
    step();
    chk("t1_first_rd", instrmem_rd, 1);
    chk("t1_first_pc", pc, 16'h3000);
    chk("t1_first_valid", instr_valid, 0);
    step();
    chk("t1_valid", instr_valid, 1);
    chk("t1_instr0", instr_out, memv(16'h3000));
    chk("t1_npc0", npc_out, 16'h3001);
    chk("t1_pc1", pc, 16'h3001);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t1_stream_instr", instr_out, memv(16'(16'h3000 + i)));
      chk("t1_stream_npc", npc_out, 16'h3001 + i);
      chk("t1_stream_pc", pc, 16'h3001 + i);
      chk("t1_stream_count", q_count, 1);
    end

    // 2: no pops, queue fills to DEPTH and requests stop
    enable_fetch = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) step();
    chk("t2_nreq", n_req, 4);
    chk("t2_last_pc", last_pc, 16'h3003);
    chk("t2_count", q_count, 4);
    chk("t2_rd_idle", instrmem_rd, 0);
    chk("t2_head", instr_out, memv(16'h3000));
    chk("t2_head_npc", npc_out, 16'h3001);
    enable_fetch = 1'b1;
    step();
    enable_fetch = 1'b0;
    chk("t2_pop_rd", instrmem_rd, 0);
    chk("t2_pop_count", q_count, 3);
    chk("t2_pop_head", instr_out, memv(16'h3001));
    step();
    chk("t2_refill_rd", instrmem_rd, 1);
    chk("t2_refill_pc", pc, 16'h3004);

    // 3: branch while a 3-cycle request to 3002 is outstanding
    lat = 3;
    do_reset();
    for (int i = 0; i < 7; i++) step();
    chk("t3_pre_pc", pc, 16'h3002);
    chk("t3_pre_count", q_count, 2);
    br_taken = 1'b1;
    taddr = 16'h4000;
    step();
    br_taken = 1'b0;
    chk("t3_sq_rd", instrmem_rd, 1);
    chk("t3_sq_pc", pc, 16'h3002);
    chk("t3_sq_count", q_count, 0);
    chk("t3_sq_valid", instr_valid, 0);
    step();
    chk("t3_sq_hold_pc", pc, 16'h3002);
    step();
    chk("t3_redir_pc", pc, 16'h4000);
    chk("t3_redir_count", q_count, 0);
    chk("t3_redir_valid", instr_valid, 0);
    lat = 1;
    for (int i = 0; i < 10 && !instr_valid; i++) step();
    chk("t3_got_valid", instr_valid, 1);
    chk("t3_first_instr", instr_out, memv(16'h4000));
    chk("t3_first_npc", npc_out, 16'h4001);

    // 4: branch together with a pop and a completion
    enable_fetch = 1'b1;
    br_taken = 1'b1;
    taddr = 16'h4100;
    step();
    br_taken = 1'b0;
    chk("t4_count", q_count, 0);
    chk("t4_valid", instr_valid, 0);
    chk("t4_pc", pc, 16'h4100);
    step();
    chk("t4_valid_after", instr_valid, 1);
    chk("t4_instr", instr_out, memv(16'h4100));
    chk("t4_npc", npc_out, 16'h4101);

    // 5: address wrap at FFFF
    br_taken = 1'b1;
    taddr = 16'hFFFF;
    step();
    br_taken = 1'b0;
    chk("t5_pc_ffff", pc, 16'hFFFF);
    chk("t5_count0", q_count, 0);
    step();
    chk("t5_pc_0000", pc, 16'h0000);
    chk("t5_instr_ffff", instr_out, memv(16'hFFFF));
    chk("t5_npc_ffff", npc_out, 16'h0000);
    step();
    chk("t5_instr_0000", instr_out, memv(16'h0000));
    chk("t5_npc_0000", npc_out, 16'h0001);
    chk("t5_pc_0001", pc, 16'h0001);

    // 6: reset with a request outstanding and the queue half full
    enable_fetch = 1'b0;
    lat = 3;
    step();
    chk("t6_pre_count", q_count, 2);
    chk("t6_pre_rd", instrmem_rd, 1);
    chk("t6_pre_pc", pc, 16'h0002);
    #2;
    reset = 1'b0;
    complete_instr = 1'b0;
    #1;
    chk("t6_rst_rd", instrmem_rd, 0);
    chk("t6_rst_pc", pc, 16'h3000);
    chk("t6_rst_valid", instr_valid, 0);
    chk("t6_rst_instr", instr_out, 0);
    chk("t6_rst_npc", npc_out, 0);
    chk("t6_rst_count", q_count, 0);
    @(negedge clock);
    reset = 1'b1;
    complete_instr = 1'b1;
    Instr_dout = 16'hDEAD;
    wcnt = 0;
    lat = 1;
    step();
    chk("t6_restart_rd", instrmem_rd, 1);
    chk("t6_restart_pc", pc, 16'h3000);
    chk("t6_stray_count", q_count, 0);
    chk("t6_stray_valid", instr_valid, 0);
    step();
    chk("t6_restart_instr", instr_out, memv(16'h3000));
    chk("t6_restart_npc", npc_out, 16'h3001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
